uart_rx_queue: RTL

UART_RX_QUEUE -- requirements
Module: uart_rx_queue

---
 rtl/spart_pkg.sv | 21 ++
 rtl/rxq_mem.sv | 37 +++
 rtl/uart_rx_queue.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// ---------------------------------------------------------------------------
// spart_pkg -- shared definitions for the UART receive queue.
//
// Contents:
//   rxq_state_t          queue occupancy/staleness FSM state encoding
//   RXQ_DEPTH_DEFAULT    default number of byte entries
//   RXQ_TIMEOUT_DEFAULT  default idle clk cycles before a non-empty queue
//                        is flagged stale
// ---------------------------------------------------------------------------
package spart_pkg;

  localparam int unsigned RXQ_DEPTH_DEFAULT   = 8;
  localparam logic [15:0] RXQ_TIMEOUT_DEFAULT = 16'd4000;

  typedef enum logic [1:0] {
    RXQ_EMPTY  = 2'd0,
    RXQ_ACTIVE = 2'd1,
    RXQ_STALE  = 2'd2
  } rxq_state_t;

endpackage : spart_pkg

// File: rtl/rxq_mem.sv
// ---------------------------------------------------------------------------
// rxq_mem -- DEPTH x 8 byte storage for the UART receive queue.
//
// One synchronous write port, one asynchronous (combinational) read port.
// Contents are not reset; the owning queue tracks validity via its pointers.
//
// Ports:
//   clk_i    clock, writes on posedge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i
// ---------------------------------------------------------------------------
module rxq_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : rxq_mem

// File: rtl/uart_rx_queue.sv
// ---------------------------------------------------------------------------
// uart_rx_queue -- byte queue between a UART receiver and a bus reader, with
// a fill-level / staleness interrupt and an optional sticky overrun flag.
//
// Build option: define UART_RXQ_OVERRUN_EN to enable the sticky overrun flag.
// Without it, overrun is tied to 0, ovr_clr is ignored, and bytes arriving
// while full are still dropped silently.
//
// Parameters:
//   DEPTH    number of byte entries (power of two, >= 2)
//   TIMEOUT  idle clk cycles before a non-empty queue is flagged stale
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   rx_data    byte from upstream receiver
//   rx_rdy     one-cycle strobe qualifying rx_data
//   rd_en      pop request
//   watermark  irq fill threshold (0 disables the threshold term)
//   ovr_clr    clears sticky overrun
//   rd_data    head entry, show-ahead (undefined while empty)
//   count      current occupancy
//   empty      count == 0
//   full       count == DEPTH
//   irq        registered service request
//   overrun    sticky byte-lost flag
//
// Transfer rules: a push happens in any cycle with rx_rdy=1 and either room
// in the queue or a pop in the same cycle; there is no backpressure, so a
// byte offered while full with no pop is lost. A pop happens in any cycle
// with rd_en=1 and empty=0; rd_data already shows the byte being popped.
// ---------------------------------------------------------------------------
module uart_rx_queue
  import spart_pkg::*;
#(
  parameter int unsigned DEPTH   = RXQ_DEPTH_DEFAULT,
  parameter logic [15:0] TIMEOUT = RXQ_TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_rdy,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH):0]   watermark,
  input  logic                     ovr_clr,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     irq,
  output logic                     overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [15:0]   idle_q,   idle_d;
  rxq_state_t    state_q,  state_d;
  logic          irq_q,    irq_d;

  logic empty_w;
  logic full_w;
  logic do_pop;
  logic do_wr;

  // ---------------------------------------------------------------------
  // Pointer / occupancy datapath
  // ---------------------------------------------------------------------
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // A pop while full frees the slot the same-cycle write lands in, so the
  // write is accepted; a pop while empty is ignored, so rx_rdy+rd_en on an
  // empty queue is a plain write.
  assign do_pop = rd_en & ~empty_w;
  assign do_wr  = rx_rdy & (~full_w | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_wr, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // Staleness FSM and idle counter
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;

    case (state_q)
      RXQ_EMPTY: begin
        if (do_wr) begin
          state_d = RXQ_ACTIVE;
        end
      end
      RXQ_ACTIVE: begin
        if (count_d == '0) begin
          state_d = RXQ_EMPTY;
        end else if (!(do_wr || do_pop) && (idle_q == TIMEOUT - 16'd1)) begin
          // Traffic in the same cycle restarts the idle window instead.
          state_d = RXQ_STALE;
        end
      end
      RXQ_STALE: begin
        if (count_d == '0) begin
          state_d = RXQ_EMPTY;
        end else if (do_wr || do_pop) begin
          state_d = RXQ_ACTIVE;
        end
      end
      default: begin
        state_d = RXQ_EMPTY;
      end
    endcase

    // Saturate rather than wrap so a long idle stretch cannot alias back
    // onto the compare value.
    if (do_wr || do_pop) begin
      idle_d = 16'd0;
    end else if ((state_q == RXQ_ACTIVE) && (idle_q != 16'hFFFF)) begin
      idle_d = idle_q + 16'd1;
    end

    // Built from next-state values so irq lines up one cycle after its cause.
    irq_d = ((watermark != '0) && (count_d >= watermark)) ||
            (state_d == RXQ_STALE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idle_q   <= 16'd0;
      state_q  <= RXQ_EMPTY;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idle_q   <= idle_d;
      state_q  <= state_d;
      irq_q    <= irq_d;
    end
  end

  // ---------------------------------------------------------------------
  // Sticky overrun flag
  // ---------------------------------------------------------------------
`ifdef UART_RXQ_OVERRUN_EN
  logic ovr_q, ovr_d;
  logic drop;

  assign drop = rx_rdy & full_w & ~do_pop;

  always_comb begin
    ovr_d = ovr_q;
    if (drop) begin
      ovr_d = 1'b1;           // a new loss beats a same-cycle clear
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun = ovr_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr;
  assign overrun        = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  rxq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (do_wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign count = count_q;
  assign empty = empty_w;
  assign full  = full_w;
  assign irq   = irq_q;

endmodule : uart_rx_queue
